// File: rtl/led_sched_pkg.sv
// led_sched_pkg: source indices, pattern geometry, FSM encoding and grant decode for the LED scheduler
package led_sched_pkg;

    localparam int NUM_SRC = 3;
    localparam int PAT_LEN = 8;

    localparam int SRC_HB  = 0;
    localparam int SRC_ACT = 1;
    localparam int SRC_ERR = 2;

    typedef enum logic [1:0] {IDLE, OWN, HOLD} state_e;

    // Highest set bit wins, so this decodes a one-hot grant and also picks the winner of a request vector
    function automatic logic [1:0] gnt_to_idx(input logic [NUM_SRC-1:0] gnt);
        return gnt[SRC_ERR] ? 2'(SRC_ERR) : gnt[SRC_ACT] ? 2'(SRC_ACT) : 2'(SRC_HB);
    endfunction

endpackage

// File: rtl/led_status_scheduler_if.sv
// led_status_scheduler_if: status-source requests and patterns in, grant and LED pins out
interface led_status_scheduler_if;
    import led_sched_pkg::*;

    logic [NUM_SRC-1:0]         REQ;
    logic [NUM_SRC*PAT_LEN-1:0] LED1_PAT;
    logic [NUM_SRC*PAT_LEN-1:0] LED2_PAT;
    logic [3:0]                 DIM;
    logic [NUM_SRC-1:0]         GNT;
    logic                       BUSY;
    logic                       LED1;
    logic                       LED2;

    modport master (output REQ, LED1_PAT, LED2_PAT, DIM, input GNT, BUSY, LED1, LED2);
    modport slave  (input REQ, LED1_PAT, LED2_PAT, DIM, output GNT, BUSY, LED1, LED2);

endinterface

// File: rtl/led_tick_gen.sv
// led_tick_gen: free-running prescaler, TICK is high one cycle in every TICK_DIV
module led_tick_gen #(
    parameter int TICK_DIV = 6250000
) (
    input  logic CLK,
    input  logic RST,
    output logic TICK
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    // Flag the last count of the period and wrap back to zero there
    always_comb begin
        TICK  = cnt_q == CW'(TICK_DIV - 1);
        cnt_d = TICK ? '0 : cnt_q + 1'b1;
    end

    // Prescaler count register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_status_scheduler.sv
// led_status_scheduler: priority arbiter with minimum hold that plays the owner's blink pattern on two LEDs
// Optional PWM dimming through DIM when LED_DIM_EN is defined
module led_status_scheduler
    import led_sched_pkg::*;
#(
    parameter int TICK_DIV = 6250000,
    parameter int MIN_HOLD = 4
) (
    input  logic CLK,
    input  logic RST,
    led_status_scheduler_if.slave bus
);

    localparam int HW = MIN_HOLD > 0 ? $clog2(MIN_HOLD + 1) : 1;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] gnt_q, gnt_d, win_oh;
    logic [2:0]         phase_q, phase_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               busy_q, busy_d;
    logic               led1_q, led1_d;
    logic               led2_q, led2_d;
    logic [1:0]         own_idx, win_idx;
    logic               tick, new_gnt, dim_on;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .TICK (tick)
    );

`ifdef LED_DIM_EN
    logic [3:0] pwm_q, pwm_d;

    // PWM phase advances every clock; a lit LED is on only while the phase is within DIM
    always_comb begin
        pwm_d  = pwm_q + 1'b1;
        dim_on = pwm_q <= bus.DIM;
    end

    // PWM phase register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) pwm_q <= '0;
        else     pwm_q <= pwm_d;
    end
`else
    logic unused_dim;
    assign unused_dim = ^bus.DIM;
    assign dim_on     = 1'b1;
`endif

    assign own_idx = gnt_to_idx(gnt_q);
    assign win_idx = gnt_to_idx(bus.REQ);
    assign win_oh  = (|bus.REQ) ? (NUM_SRC'(1) << win_idx) : '0;

    // Arbitration: a higher request preempts at once, the owner lets go only after its hold expires
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        if (state_q == IDLE) begin
            if (|bus.REQ) begin
                state_d = OWN;
                gnt_d   = win_oh;
            end
        end else if (win_idx > own_idx || (!bus.REQ[own_idx] && hold_q == '0)) begin
            state_d = (|bus.REQ) ? OWN : IDLE;
            gnt_d   = win_oh;
        end else begin
            state_d = bus.REQ[own_idx] ? OWN : HOLD;
        end
        new_gnt = gnt_d != gnt_q && |gnt_d;
        phase_d = gnt_d != gnt_q ? '0 : phase_q + 3'(tick);
        hold_d  = new_gnt ? HW'(MIN_HOLD) : hold_q - HW'(tick && hold_q != '0);
        busy_d  = |gnt_d;
    end

    // LED drive from the current owner's live pattern; dark when nobody owns the LEDs
    always_comb begin
        led1_d = 1'b0;
        led2_d = 1'b1;
        if (|gnt_q) begin
            led1_d = bus.LED1_PAT[{own_idx, phase_q}] & dim_on;
            led2_d = ~(bus.LED2_PAT[{own_idx, phase_q}] & dim_on);
        end
    end

    // State, grant, step, hold and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            phase_q <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            led1_q  <= 1'b0;
            led2_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            phase_q <= phase_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            led1_q  <= led1_d;
            led2_q  <= led2_d;
        end
    end

    assign bus.GNT  = gnt_q;
    assign bus.BUSY = busy_q;
    assign bus.LED1 = led1_q;
    assign bus.LED2 = led2_q;

endmodule

// File: tb/tb_led_status_scheduler.sv
// tb_led_status_scheduler: randomized stimulus, reference model feeding a scoreboard checked at the falling edge
module tb_led_status_scheduler;

    localparam int TD = 4;
    localparam int MH = 2;

    typedef struct packed {
        logic [2:0] gnt;
        logic       busy;
        logic       led1;
        logic       led2;
        logic       tick;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    exp_t exp_q[$];
    int   m_owner = -1;
    int   m_phase = 0;
    int   m_hold  = 0;
    int   m_pcnt  = 0;
    int   m_pwm   = 0;

    led_status_scheduler_if bus();

    led_status_scheduler #(.TICK_DIV(TD), .MIN_HOLD(MH)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, req);
        end
    endtask

    // Reference: owner moves up on any higher request, moves elsewhere only when the owner has
    // dropped and its hold has run out; LEDs show the previous owner's step one cycle late
    task automatic model_step();
        int   win, nxt;
        bit   tk, l1, l2;
        exp_t e;
        tk  = m_pcnt == TD - 1;
        win = -1;
        for (int i = 0; i < 3; i++) if (bus.REQ[i]) win = i;
        l1 = 0;
        l2 = 0;
        if (m_owner >= 0) begin
            l1 = bus.LED1_PAT[8*m_owner+m_phase];
            l2 = bus.LED2_PAT[8*m_owner+m_phase];
        end
`ifdef LED_DIM_EN
        if (m_pwm > int'(bus.DIM)) begin
            l1 = 0;
            l2 = 0;
        end
`endif
        nxt = m_owner;
        if (win > m_owner) nxt = win;
        else if (m_owner >= 0 && !bus.REQ[m_owner] && m_hold == 0) nxt = win;
        if (nxt != m_owner) begin
            m_phase = 0;
            if (nxt >= 0) m_hold = MH;
        end else if (tk) begin
            m_phase = (m_phase + 1) % 8;
            if (m_hold > 0) m_hold--;
        end
        m_owner = nxt;
        m_pcnt  = (m_pcnt + 1) % TD;
        m_pwm   = (m_pwm + 1) % 16;
        e.gnt   = nxt >= 0 ? 3'(1 << nxt) : 3'b000;
        e.busy  = nxt >= 0;
        e.led1  = l1;
        e.led2  = !l2;
        e.tick  = m_pcnt == TD - 1;
        exp_q.push_back(e);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_phase = 0;
            m_hold  = 0;
            m_pcnt  = 0;
            m_pwm   = 0;
            exp_q.delete();
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("gnt",  32'(bus.GNT),          32'(e.gnt));
            check("busy", 32'(bus.BUSY),         32'(e.busy));
            check("led1", 32'(bus.LED1),         32'(e.led1));
            check("led2", 32'(bus.LED2),         32'(e.led2));
            check("tick", 32'(dut.u_tick.TICK),  32'(e.tick));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_tick();
        int n = 0;
        while (m_pcnt != TD - 1 && n < 4 * TD) begin
            cyc();
            n++;
        end
        if (m_pcnt != TD - 1) begin
            checks++;
            errors++;
            $display("FAIL tick_wait: no tick within %0d cycles", 4 * TD);
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_gnt",  32'(bus.GNT),  32'(3'b000));
        check("rst_busy", 32'(bus.BUSY), 32'(1'b0));
        check("rst_led1", 32'(bus.LED1), 32'(1'b0));
        check("rst_led2", 32'(bus.LED2), 32'(1'b1));
        cycles(2);
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.REQ      = '0;
        bus.LED1_PAT = '0;
        bus.LED2_PAT = '0;
        bus.DIM      = 4'd15;
        cycles(3);
        rst = 1'b0;
        cycles(3);

        bus.REQ      = 3'b001;
        bus.LED1_PAT = 24'h000005;
        bus.LED2_PAT = 24'h0000FF;
        cyc();
        check("first_gnt",  32'(bus.GNT),  32'(3'b001));
        check("first_busy", 32'(bus.BUSY), 32'(1'b1));
        cycles(40);

        bus.REQ = 3'b101;
        cyc();
        check("preempt_gnt", 32'(bus.GNT), 32'(3'b100));
        cycles(10);

        bus.REQ = 3'b000;
        cycles(12);
        check("release_gnt", 32'(bus.GNT), 32'(3'b000));
        bus.LED1_PAT = 24'hA5C3F0;
        bus.LED2_PAT = 24'h3C0FF1;
        bus.REQ = 3'b010;
        cyc();
        wait_tick();
        cyc();
        bus.REQ = 3'b000;
        cyc();
        check("hold_keeps", 32'(bus.GNT), 32'(3'b010));
        cycles(12);
        check("hold_done_gnt",  32'(bus.GNT),  32'(3'b000));
        check("hold_done_busy", 32'(bus.BUSY), 32'(1'b0));
        check("hold_done_led2", 32'(bus.LED2), 32'(1'b1));

        bus.REQ = 3'b001;
        cycles(6);
        wait_tick();
        bus.REQ = 3'b101;
        cyc();
        check("collide_gnt", 32'(bus.GNT), 32'(3'b100));
        cycles(20);

        bus.DIM = 4'd3;
        bus.LED1_PAT = 24'hFFFFFF;
        cycles(40);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) bus.REQ = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) begin
                bus.LED1_PAT = 24'($urandom);
                bus.LED2_PAT = 24'($urandom);
            end
            if ($urandom_range(0, 63) == 0) bus.DIM = 4'($urandom);
            if (i == 700) begin
                bus.REQ = 3'b100;
                cycles(7);
                do_reset();
            end
            cyc();
        end

        cycles(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_status_scheduler.md
Name: led_status_scheduler

Overview:
- Shares the board's two status LEDs (LED1, LED2) between three status sources: heartbeat (0), activity (1) and error (2).
- Fixed priority: higher index wins. A minimum ownership time stops short requests from flickering.
- Each source supplies an 8-step blink pattern per LED. A prescaled tick derived from the 100 MHz CLK steps through the granted source's pattern.
- Sits between status sources in the design and the top-level LED pins.

Parameters:
- TICK_DIV, 6250000, CLK cycles per pattern step (16 Hz at 100 MHz); must be >= 2.
- MIN_HOLD, 4, minimum ownership in ticks after a grant; 0 means no hold.

Ports:
- CLK  input  1  system clock, 100 MHz.
- RST  input  1  asynchronous reset, active-high.
- REQ  input  3  request per source; bit i = source i.
- LED1_PAT  input  24  LED1 patterns; bits [8i+7:8i] belong to source i; bit 8i+k is step k.
- LED2_PAT  input  24  LED2 patterns; same layout as LED1_PAT.
- DIM  input  4  brightness; used only with LED_DIM_EN.
- GNT  output  3  one-hot current owner; 000 = none.
- BUSY  output  1  high when any source owns the LEDs.
- LED1  output  1  active-high LED pin.
- LED2  output  1  active-low LED pin (inverted drive).

Behaviour:
- Reset values (async, immediate): GNT=000, BUSY=0, LED1=0, LED2=1 (both LEDs dark). Prescaler, phase and hold counter = 0. State = IDLE.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick is high for exactly one cycle when the count equals TICK_DIV-1.
  - Free-running and independent of arbitration.
- Phase: 3-bit step index. Increments on tick and wraps 7 -> 0. Forced to 0 on any change of owner.
- Hold counter: loaded with MIN_HOLD on every new grant. Decrements on tick while nonzero.
- Winner: highest-index asserted REQ bit.
- State machine, evaluated every cycle; GNT is registered and updates on the cycle after the deciding REQ:
  - IDLE: if REQ != 0, grant the winner -> OWN.
  - OWN:
    - A REQ bit above the owner is asserted: preempt immediately and grant the new winner, regardless of the hold counter.
    - Owner's REQ drops and hold counter = 0: grant the current winner if REQ != 0 (-> OWN), else -> IDLE with GNT=000.
    - Owner's REQ drops and hold counter > 0: -> HOLD.
    - Lower-priority requests never preempt.
  - HOLD:
    - The owner keeps its pattern while the hold counter is nonzero.
    - A higher-priority request preempts as in OWN.
    - Owner re-asserts REQ: -> OWN.
    - Hold counter reaches 0: resolve as in OWN when the owner's REQ has dropped.
- Same-cycle tick and grant change: the grant wins. Phase = 0, hold counter = MIN_HOLD, no decrement that cycle.
- Outputs:
  - Registered, one cycle after GNT/phase update.
  - LED1 = LED1_PAT[8*owner+phase].
  - LED2 = ~LED2_PAT[8*owner+phase].
  - In IDLE, both LEDs are dark.
- Pattern inputs are sampled live every cycle, not latched at grant.
- BUSY = (GNT != 000), registered alongside GNT.
- Reset asserted mid-pattern: all state returns to reset values immediately. After release, arbitration restarts from IDLE with a fresh prescaler.

Optional Feature:
- Macro: LED_DIM_EN.
- Defined:
  - A free-running 4-bit PWM counter advances every CLK cycle.
  - A lit LED is driven on only while pwm_cnt <= DIM: DIM=15 gives full on, DIM=0 gives 1/16 duty.
  - A dark LED stays dark.
  - LED2 polarity is unchanged (active-low).
- Undefined: DIM is ignored and lit LEDs are fully on. No PWM logic is synthesised.

Decomposition:
- Package led_sched_pkg holds:
  - Source indices: SRC_HB=0, SRC_ACT=1, SRC_ERR=2.
  - NUM_SRC=3 and PAT_LEN=8.
  - The state enum: IDLE, OWN, HOLD.
  - A function mapping one-hot GNT to an index.
- Sub-module led_tick_gen: the prescaler. Parameter TICK_DIV; ports CLK, RST, TICK.

Test Plan (TICK_DIV=4, MIN_HOLD=2):
- Reset: RST pulsed mid-simulation -> LED1=0, LED2=1, GNT=000, BUSY=0 immediately; first tick 4 cycles after release, then every 4 cycles.
- Single source: REQ=001, LED1_PAT[7:0]=8'b0000_0101, LED2_PAT[7:0]=8'hFF -> GNT=001 one cycle later; over successive ticks LED1 = 1,0,1,0,0,0,0,0 then repeats; LED2 held 0.
- Preemption: owner 0, raise REQ[2] -> GNT=100 next cycle, phase restarts at step 0, hold counter = 2 despite source 0's remaining hold.
- Hold: grant source 1, drop REQ[1] after 1 tick -> GNT stays 010 until the 2nd tick after the grant, then GNT=000, LEDs dark, BUSY=0.
- Tick collision: raise REQ[2] on the exact cycle tick is high -> phase=0 and hold=2; no step advance or decrement that cycle.
- Dimming (LED_DIM_EN, DIM=3, lit LED1): LED1 high 4 of every 16 cycles; without the macro, LED1 high continuously.
